inst_enc: RTL and testbench
===========================

# inst_enc

Instruction encoder: the packing counterpart of the immediate generator. It accepts decomposed RV32I fields (format, opcode, registers, functs, full 32-bit immediate) over a valid/ready handshake, range-checks the immediate for the format, packs the 32-bit instruction word, and queues it with a running byte address in a small output FIFO. It feeds the instruction-memory loader and is used by the self-test program builder, so that encoded words round-trip through the immediate generator unchanged.

## Interface
- DEPTH, 2: output FIFO entries (≥1).
- ADDR_W, 14: width of the instruction byte address.

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  field set presented
- in_ready  out  1  encoder can accept; transfer when in_valid & in_ready
- in_fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 invalid
- in_opcode  in  7  opcode placed in inst[6:0]
- in_rd / in_rs1 / in_rs2  in  5 each  register indices
- in_funct3  in  3;  in_funct7  in  7
- in_imm  in  32  byte-offset immediate, sign-extended value
- addr_clr  in  1  synchronous restart of address counter
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer takes head when out_valid & out_ready
- out_inst  out  32  packed word (0 when empty)
- out_addr  out  ADDR_W  byte address of out_inst (0 when empty)
- out_err  out  1  immediate out of range / invalid fmt for head entry
- err_cnt  out  8  saturating count of accepted errored entries

## Operation
- Packing (fields outside a format ignored): R: funct7|rs2|rs1|funct3|rd|op. I: imm[11:0]|rs1|funct3|rd|op. S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|op. B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op. U: imm[31:12]|rd|op. J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- Range rules (violation sets err, word still packed from truncated bits): I,S: imm[31:11] all equal. B: imm[0]=0 and imm[31:12] all equal. J: imm[0]=0 and imm[31:20] all equal. U: imm[11:0]=0. R: never errs.
- Invalid fmt (6,7): word = 32'h0000_0013 (NOP), err=1.
- Address: each accepted entry gets the current counter value; counter += 4 after accept, wraps mod 2^ADDR_W. addr_clr sets counter to 0; if coincident with an accept, that entry gets address 0 and counter becomes 4.
- err_cnt increments on each accepted errored entry, holds at 255.
- FIFO: in-order, count 0..DEPTH. in_ready = (count != DEPTH), from registered state only (no out_ready→in_ready path). Push and pop in same cycle: count unchanged. Pop when empty ignored.

## Timing
- Reset (async assert, sync release): FIFO empty, pointers 0, address counter 0, err_cnt 0; out_valid=0, out_inst=0, out_addr=0, out_err=0, in_ready=1.
- Latency: fields accepted at edge N appear at FIFO head (out_valid=1) after edge N, i.e. visible in cycle N+1 if FIFO was empty.
- Throughput: one instruction per cycle while out_ready held high.
- out_* stable while out_valid=1 and out_ready=0.
- Full: in_ready=0 in the cycle after the DEPTH-th push without pop; returns to 1 the cycle after a pop.
- Reset mid-operation discards all queued entries and the address; first post-reset entry gets address 0.

## Test plan
- I-type addi x1,x0,-1 (fmt=1, op=0x13, rd=1, rs1=0, f3=0, imm=0xFFFFFFFF) -> out_inst=0xFFF00093, out_err=0, out_addr=0, out_valid one cycle after accept.
- B-type beq x1,x2,-4 (fmt=3, op=0x63, rs1=1, rs2=2, imm=0xFFFFFFFC) then J-type jal x1,2048 (fmt=5, op=0x6F, rd=1, imm=0x800) -> 0xFE208EE3 @addr 0, 0x001000EF @addr 4.
- U-type lui x5 imm=0x12345000 -> 0x123452B7, err=0; imm=0x12345001 -> err=1, err_cnt=1; I-type imm=0x800 rd=0 rs1=0 op=0x13 -> 0x80000013, err=1, err_cnt=2; fmt=7 -> 0x00000013, err=1.
- Backpressure: out_ready=0, offer 3 entries -> in_ready drops after 2nd accept, 3rd held; out_ready=1 -> outputs in order at addrs 0,4,8, head stable while stalled.
- ADDR_W=4: 5 accepts -> addrs 0,4,8,12,0; addr_clr with 3rd accept -> addrs 0,4,0,4.
- Assert rst_n low with 2 queued entries -> out_valid=0, in_ready=1, err_cnt=0 immediately; next entry at addr 0.

Source files
------------

// File: rtl/inst_enc_if.sv
// inst_enc_if: field-in / instruction-out handshake bundle for the instruction encoder
interface inst_enc_if #(parameter int ADDR_W = 14);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_fmt;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;
    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_addr, out_err
    );
    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_addr, out_err
    );
endinterface

// File: rtl/inst_enc.sv
// inst_enc: packs RV32I fields into instruction words and queues them with byte addresses
module inst_enc #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 14
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       addr_clr,
    output logic [7:0] err_cnt,
    inst_enc_if.slave  bus
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [31:0]       imm, word;
    logic              err, ok11, ok12, ok20, push, pop;
    logic [31:0]       m_inst [DEPTH];
    logic [ADDR_W-1:0] m_addr [DEPTH];
    logic              m_err  [DEPTH];
    logic [PW-1:0]     wp, rp;
    logic [CW-1:0]     cnt;
    logic [ADDR_W-1:0] pc, base;
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction
    assign imm  = bus.in_imm;
    assign ok11 = &imm[31:11] | ~|imm[31:11];
    assign ok12 = &imm[31:12] | ~|imm[31:12];
    assign ok20 = &imm[31:20] | ~|imm[31:20];
    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;
    assign base = addr_clr ? '0 : pc;
    assign bus.in_ready  = cnt != CW'(DEPTH);
    assign bus.out_valid = cnt != '0;
    assign bus.out_inst  = bus.out_valid ? m_inst[rp] : '0;
    assign bus.out_addr  = bus.out_valid ? m_addr[rp] : '0;
    assign bus.out_err   = bus.out_valid & m_err[rp];
    // format-dependent packing and immediate range check; invalid formats become a flagged NOP
    always_comb begin
        word = bus.in_fmt == 3'd0 ? {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode} :
               bus.in_fmt == 3'd1 ? {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode} :
               bus.in_fmt == 3'd2 ? {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], bus.in_opcode} :
               bus.in_fmt == 3'd3 ? {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:1], imm[11], bus.in_opcode} :
               bus.in_fmt == 3'd4 ? {imm[31:12], bus.in_rd, bus.in_opcode} :
               bus.in_fmt == 3'd5 ? {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode} :
                                    32'h0000_0013;
        err  = bus.in_fmt == 3'd0 ? 1'b0 :
               bus.in_fmt <= 3'd2 ? ~ok11 :
               bus.in_fmt == 3'd3 ? imm[0] | ~ok12 :
               bus.in_fmt == 3'd4 ? |imm[11:0] :
               bus.in_fmt == 3'd5 ? imm[0] | ~ok20 :
                                    1'b1;
    end
    // FIFO payload storage; validity is tracked by cnt, so no reset is needed here
    always_ff @(posedge clk) begin
        if (push) begin
            m_inst[wp] <= word;
            m_addr[wp] <= base;
            m_err[wp]  <= err;
        end
    end
    // FIFO pointers, occupancy, address counter and saturating error count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp      <= '0;
            rp      <= '0;
            cnt     <= '0;
            pc      <= '0;
            err_cnt <= '0;
        end else begin
            wp      <= push ? inc(wp) : wp;
            rp      <= pop ? inc(rp) : rp;
            cnt     <= cnt + CW'(push) - CW'(pop);
            pc      <= base + (push ? ADDR_W'(4) : '0);
            err_cnt <= err_cnt + 8'(push & err & (err_cnt != 8'hFF));
        end
    end
endmodule

// File: tb/tb_inst_enc.sv
// tb_inst_enc: table-driven, scoreboarded bench for inst_enc at ADDR_W=14 and ADDR_W=4 side by side
module tb_inst_enc;
    logic clk = 0, rst_n = 1, addr_clr = 0;
    logic in_valid = 0, out_ready = 1;
    logic [2:0] fmt = 0, f3 = 0;
    logic [6:0] op = 0, f7 = 0;
    logic [4:0] rd = 0, rs1 = 0, rs2 = 0;
    logic [31:0] imm = 0;
    logic [7:0] ec_a, ec_b;
    always #5 clk = ~clk;

    inst_enc_if #(.ADDR_W(14)) ia();
    inst_enc_if #(.ADDR_W(4))  ib();
    assign ia.in_valid = in_valid;  assign ib.in_valid = in_valid;
    assign ia.in_fmt = fmt;         assign ib.in_fmt = fmt;
    assign ia.in_opcode = op;       assign ib.in_opcode = op;
    assign ia.in_rd = rd;           assign ib.in_rd = rd;
    assign ia.in_rs1 = rs1;         assign ib.in_rs1 = rs1;
    assign ia.in_rs2 = rs2;         assign ib.in_rs2 = rs2;
    assign ia.in_funct3 = f3;       assign ib.in_funct3 = f3;
    assign ia.in_funct7 = f7;       assign ib.in_funct7 = f7;
    assign ia.in_imm = imm;         assign ib.in_imm = imm;
    assign ia.out_ready = out_ready; assign ib.out_ready = out_ready;

    inst_enc #(.DEPTH(2), .ADDR_W(14)) u_a (.clk(clk), .rst_n(rst_n), .addr_clr(addr_clr), .err_cnt(ec_a), .bus(ia.slave));
    inst_enc #(.DEPTH(2), .ADDR_W(4))  u_b (.clk(clk), .rst_n(rst_n), .addr_clr(addr_clr), .err_cnt(ec_b), .bus(ib.slave));

    typedef struct {
        logic [2:0] fmt; logic [6:0] op; logic [4:0] rd, rs1, rs2;
        logic [2:0] f3; logic [6:0] f7; logic [31:0] imm;
        logic [31:0] inst; logic err;
    } vec_t;
    typedef struct { logic [31:0] inst; logic [13:0] addr; logic err; } exp_t;

    vec_t tbl [13];
    exp_t q [$];
    int total = 0, bad = 0, m_ec = 0;
    logic [13:0] m_pc = 0;
    logic [31:0] e_inst = 0, head = 0;
    logic e_err = 0, acc = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    // one clock: sample at negedge, update model for the coming edge, compare err_cnt after it
    task automatic cyc();
        exp_t x;
        logic [13:0] a;
        @(negedge clk);
        acc = in_valid && ia.in_ready;
        chk("valid4", ib.out_valid, ia.out_valid);
        if (ia.out_valid && out_ready) begin
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_out: got %h want nothing", ia.out_inst);
            end else begin
                x = q.pop_front();
                chk("inst", ia.out_inst, x.inst);
                chk("addr", 32'(ia.out_addr), 32'(x.addr));
                chk("err", 32'(ia.out_err), 32'(x.err));
                chk("inst4", ib.out_inst, x.inst);
                chk("addr4", 32'(ib.out_addr), 32'(x.addr[3:0]));
                chk("err4", 32'(ib.out_err), 32'(x.err));
            end
        end
        if (acc) begin
            a = addr_clr ? 14'd0 : m_pc;
            q.push_back('{e_inst, a, e_err});
            m_pc = a + 14'd4;
            if (e_err && m_ec < 255) m_ec++;
        end else if (addr_clr) m_pc = 0;
        @(posedge clk); #1;
        chk("err_cnt", 32'(ec_a), 32'(m_ec));
        chk("err_cnt4", 32'(ec_b), 32'(m_ec));
    endtask

    task automatic apply(input int i);
        fmt = tbl[i].fmt; op = tbl[i].op; rd = tbl[i].rd; rs1 = tbl[i].rs1; rs2 = tbl[i].rs2;
        f3 = tbl[i].f3; f7 = tbl[i].f7; imm = tbl[i].imm;
        e_inst = tbl[i].inst; e_err = tbl[i].err;
    endtask

    task automatic send(input int i, output int n);
        apply(i);
        in_valid = 1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(); n++;
            if (acc) break;
        end
        if (!acc) begin
            total++; bad++;
            $display("FAIL accept_timeout: got none want accept of vector %0d", i);
        end
        in_valid = 0;
    endtask

    task automatic drain();
        out_ready = 1;
        for (int k = 0; k < 20 && q.size() > 0; k++) cyc();
        cyc();
        chk("drained", q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 0;
        #2;
        chk("rst_valid", ia.out_valid, 0);
        chk("rst_ready", ia.in_ready, 1);
        chk("rst_inst", ia.out_inst, 0);
        chk("rst_addr", 32'(ia.out_addr), 0);
        chk("rst_err", ia.out_err, 0);
        chk("rst_err_cnt", 32'(ec_a), 0);
        chk("rst_valid4", ib.out_valid, 0);
        q.delete(); m_pc = 0; m_ec = 0;
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int n;
        tbl[0]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0};
        tbl[1]  = '{3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0};
        tbl[2]  = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 32'h0010_00EF, 1'b0};
        tbl[3]  = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000, 32'h1234_52B7, 1'b0};
        tbl[4]  = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5001, 32'h1234_52B7, 1'b1};
        tbl[5]  = '{3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 32'h8000_0013, 1'b1};
        tbl[6]  = '{3'd7, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0000_0000, 32'h0000_0013, 1'b1};
        tbl[7]  = '{3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEAD_BEEF, 32'h4020_81B3, 1'b0};
        tbl[8]  = '{3'd2, 7'h23, 5'd7, 5'd1, 5'd2, 3'd2, 7'h00, 32'hFFFF_FFF8, 32'hFE20_AC23, 1'b0};
        tbl[9]  = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0009, 32'h0000_0463, 1'b1};
        tbl[10] = '{3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0010_0000, 32'h8000_006F, 1'b1};
        tbl[11] = '{3'd6, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 7'h00, 32'h0000_0000, 32'h0000_0013, 1'b1};
        tbl[12] = '{3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F800, 32'h8000_0013, 1'b0};
        #1;
        do_reset();

        out_ready = 1;
        send(0, n);
        chk("latency_valid", ia.out_valid, 1);
        for (int i = 1; i < 13; i++) begin
            send(i, n);
            chk("throughput", n, 1);
        end
        drain();

        out_ready = 0;
        send(0, n);
        send(1, n);
        chk("full_ready", ia.in_ready, 0);
        do_reset();
        out_ready = 1;
        send(2, n);
        drain();

        do_reset();
        out_ready = 0;
        send(0, n);
        send(1, n);
        chk("bp_ready", ia.in_ready, 0);
        apply(2);
        in_valid = 1;
        head = ia.out_inst;
        chk("bp_head", head, tbl[0].inst);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("bp_held", acc, 0);
            chk("bp_stable_inst", ia.out_inst, head);
            chk("bp_stable_addr", 32'(ia.out_addr), 0);
        end
        out_ready = 1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (acc) break;
        end
        chk("bp_third_accepted", acc, 1);
        in_valid = 0;
        drain();

        addr_clr = 1; cyc(); addr_clr = 0;
        for (int i = 0; i < 5; i++) send(i, n);
        drain();
        addr_clr = 1; cyc(); addr_clr = 0;
        send(7, n);
        send(8, n);
        addr_clr = 1;
        send(0, n);
        addr_clr = 0;
        send(3, n);
        drain();

        for (int i = 0; i < 260; i++) send(6, n);
        drain();
        chk("err_cnt_sat", 32'(ec_a), 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
